shift_ex_stage: RTL and testbench
=================================

Name: shift_ex_stage

Overview:
- Execute-stage wrapper around the existing barrel `Shifter` for the WISC-F18 pipeline.
- Accepts decoded SLL/SRA/ROR operations from ID/EX, maps the opcode to a `Shifter` Mode, and registers the result with destination info.
- Maintains the Z flag for shift instructions.
- Valid/ready handshakes on both sides allow the stage to stall behind MEM and accept flushes from branch resolution.

Parameters:
- DATA_W, 16, operand/result width (fixed at 16 for `Shifter` compatibility).
- REG_AW, 4, register-file address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- In_Valid  in  1  ID/EX presents an operation.
- In_Ready  out  1  stage can accept this cycle.
- In_Opcode  in  4  4'b0100 SLL, 4'b0101 SRA, 4'b0110 ROR; all others illegal.
- In_Rs  in  DATA_W  source operand.
- In_Imm  in  4  shift amount.
- In_Rd  in  REG_AW  destination register.
- Flush  in  1  squash held and incoming operation.
- Out_Valid  out  1  registered result available.
- Out_Ready  in  1  downstream consumes.
- Out_Result  out  DATA_W  registered shift result.
- Out_Rd  out  REG_AW  registered destination.
- Out_WrEn  out  1  register write enable for the held result.
- Z_Flag  out  1  zero flag register.
- Illegal_Op  out  1  sticky; set when an illegal opcode is accepted.

Behaviour:
- Reset (async, rst_n=0): Out_Valid=0, Out_Result=0, Out_Rd=0, Out_WrEn=0, Z_Flag=0, Illegal_Op=0. Deassertion is sampled synchronously. No state changes while rst_n=0.
- Opcode-to-Mode map:
  - SLL → Mode 0 (logical left).
  - SRA → Mode 1 (right shift as implemented by `Shifter`: zero-fill).
  - ROR → Mode 2 (rotate right).
  - Illegal opcode → Mode 3 (don't-care); the result is forced to In_Rs.
- Shift_Val = In_Imm. A shift amount of 0 returns In_Rs unchanged for all modes.
- In_Ready = !Out_Valid || Out_Ready (single output register; pass-through ready; no bubble on continuous flow).
- Accept = In_Valid && In_Ready && !Flush.
- On accept, with 1-cycle latency:
  - Out_Valid=1; Out_Result=Shifter output; Out_Rd=In_Rd.
  - Legal opcode: Out_WrEn=1 and Z_Flag updated to (result==0).
  - Illegal opcode: Out_WrEn=0, Z_Flag unchanged, Illegal_Op set to 1 (cleared only by reset).
- Consume only (Out_Valid && Out_Ready, no accept): Out_Valid=0 next cycle; Out_Result and Out_Rd hold their last values.
- Consume and accept in the same cycle: the new operation replaces the old with no gap.
- Stall (Out_Valid && !Out_Ready):
  - In_Ready=0.
  - Out_Result, Out_Rd and Out_WrEn are held stable.
  - Z_Flag holds.
- Flush has priority over every other event:
  - Next cycle Out_Valid=0 and Out_WrEn=0; the incoming operation is dropped.
  - Z_Flag retains the value from the last accepted legal operation, since flags are committed at accept.
- Out_WrEn is only meaningful while Out_Valid=1. It is cleared whenever Out_Valid falls.
- All outputs come from registers; there are no combinational paths from In_* to Out_*. The In_Ready path depends on Out_Ready.

Decomposition:
- Shared package `wisc_pkg`:
  - Opcode localparams OP_SLL, OP_SRA, OP_ROR.
  - Shift mode enum: MODE_SLL=0, MODE_SRL=1, MODE_ROR=2.
  - DATA_W and REG_AW constants.
- Sub-module: the existing `Shifter` (ports Shift_Out, Shift_In, Shift_Val, Mode), instantiated once.
- The handshake/register logic is inline and needs no further sub-module.

Test Plan:
- Reset mid-stream: drive an accepted op, assert rst_n=0 asynchronously between edges → Out_Valid, Out_WrEn, Z_Flag and Illegal_Op read 0 immediately, before the next clock edge.
- Basic ops, Out_Ready=1:
  - SLL Rs=0x8001 Imm=1 → Out_Result=0x0002, Z=0.
  - SRA Rs=0x8000 Imm=15 → 0x0001.
  - ROR Rs=0x0001 Imm=4 → 0x1000.
  - SLL Rs=0x8000 Imm=1 → 0x0000, Z=1.
  - Each result appears one cycle after accept.
- Backpressure: hold Out_Ready=0 for 3 cycles with In_Valid=1 → In_Ready=0; Out_Result stable; the second op is accepted in the cycle Out_Ready=1; back-to-back throughput of 1 op/cycle afterwards.
- Flush: assert Flush with In_Valid=1 while holding a valid result → next cycle Out_Valid=0, Out_WrEn=0, Z_Flag unchanged.
- Illegal opcode 4'b0000, Rs=0x1234 → Out_Result=0x1234, Out_WrEn=0, Illegal_Op=1 (sticky), Z_Flag unchanged.
- Exhaustive sweep: all 16 Imm values × 3 modes over random Rs, compared against a reference model → no mismatches, and Z_Flag always equals (result==0).

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC-F18 constants: datapath widths, shift opcodes and the Shifter mode encoding.
package wisc_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  // SRA is mapped onto the Shifter's zero-fill right mode, hence MODE_SRL.
  typedef enum logic [1:0] {
    MODE_SLL  = 2'd0,
    MODE_SRL  = 2'd1,
    MODE_ROR  = 2'd2,
    MODE_NONE = 2'd3
  } shift_mode_e;

  function automatic shift_mode_e op_to_mode(input logic [3:0] op);
    case (op)
      OP_SLL:  return MODE_SLL;
      OP_SRA:  return MODE_SRL;
      OP_ROR:  return MODE_ROR;
      default: return MODE_NONE;
    endcase
  endfunction

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_ex_stage_if.sv
// ID/EX -> shift stage -> MEM handshake bundle; master is the surrounding pipeline, slave is the stage.
interface shift_ex_stage_if;
  import wisc_pkg::*;

  // A transfer happens on a rising edge where valid and ready are both high; valid, once
  // raised, holds its payload stable until the transfer; ready may depend on downstream ready.
  logic              In_Valid;
  logic              In_Ready;
  logic [3:0]        In_Opcode;
  logic [DATA_W-1:0] In_Rs;
  logic [3:0]        In_Imm;
  logic [REG_AW-1:0] In_Rd;
  logic              Flush;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [DATA_W-1:0] Out_Result;
  logic [REG_AW-1:0] Out_Rd;
  logic              Out_WrEn;
  logic              Z_Flag;
  logic              Illegal_Op;

  modport master (
    output In_Valid, In_Opcode, In_Rs, In_Imm, In_Rd, Flush, Out_Ready,
    input  In_Ready, Out_Valid, Out_Result, Out_Rd, Out_WrEn, Z_Flag, Illegal_Op
  );

  modport slave (
    input  In_Valid, In_Opcode, In_Rs, In_Imm, In_Rd, Flush, Out_Ready,
    output In_Ready, Out_Valid, Out_Result, Out_Rd, Out_WrEn, Z_Flag, Illegal_Op
  );

endinterface

// File: rtl/shift_ex_stage_shifter.sv
// Barrel shifter: mode 0 logical left, 1 logical right, 2 rotate right, 3 passes the input through.
module Shifter
  import wisc_pkg::*;
(
  output logic [DATA_W-1:0] Shift_Out,
  input  logic [DATA_W-1:0] Shift_In,
  input  logic [3:0]        Shift_Val,
  input  logic [1:0]        Mode
);

  logic [2*DATA_W-1:0] rot_w;

  always_comb begin
    rot_w     = {Shift_In, Shift_In} >> Shift_Val;
    Shift_Out = Shift_In;
    case (shift_mode_e'(Mode))
      MODE_SLL: Shift_Out = Shift_In << Shift_Val;
      MODE_SRL: Shift_Out = Shift_In >> Shift_Val;
      MODE_ROR: Shift_Out = rot_w[DATA_W-1:0];
      default:  Shift_Out = Shift_In;
    endcase
  end

endmodule

// File: rtl/shift_ex_stage.sv
// Execute-stage wrapper: maps shift opcodes onto the Shifter and holds one result for MEM.
module shift_ex_stage
  import wisc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  shift_ex_stage_if.slave    bus
);

  logic              out_valid_q,  out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [REG_AW-1:0] out_rd_q,     out_rd_d;
  logic              out_wren_q,   out_wren_d;
  logic              z_flag_q,     z_flag_d;
  logic              illegal_q,    illegal_d;

  logic              in_ready;
  logic              accept;
  logic              legal;
  shift_mode_e       mode;
  logic [DATA_W-1:0] shift_out;
  logic [DATA_W-1:0] new_result;

  assign in_ready   = !out_valid_q || bus.Out_Ready;
  assign accept     = bus.In_Valid && in_ready && !bus.Flush;
  assign legal      = op_is_legal(bus.In_Opcode);
  assign mode       = op_to_mode(bus.In_Opcode);
  assign new_result = legal ? shift_out : bus.In_Rs;

  Shifter u_shifter (
    .Shift_Out (shift_out),
    .Shift_In  (bus.In_Rs),
    .Shift_Val (bus.In_Imm),
    .Mode      (mode)
  );

  // Flags commit at accept, so a flush never rolls Z back.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_wren_d   = out_wren_q;
    z_flag_d     = z_flag_q;
    illegal_d    = illegal_q;
    if (bus.Flush) begin
      out_valid_d = 1'b0;
      out_wren_d  = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = new_result;
      out_rd_d     = bus.In_Rd;
      out_wren_d   = legal;
      if (legal) z_flag_d  = (new_result == '0);
      else       illegal_d = 1'b1;
    end else if (out_valid_q && bus.Out_Ready) begin
      out_valid_d = 1'b0;
      out_wren_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_wren_q   <= 1'b0;
      z_flag_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_wren_q   <= out_wren_d;
      z_flag_q     <= z_flag_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.In_Ready   = in_ready;
  assign bus.Out_Valid  = out_valid_q;
  assign bus.Out_Result = out_result_q;
  assign bus.Out_Rd     = out_rd_q;
  assign bus.Out_WrEn   = out_wren_q;
  assign bus.Z_Flag     = z_flag_q;
  assign bus.Illegal_Op = illegal_q;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Directed bench for shift_ex_stage: basic ops, backpressure, flush, illegal opcode, mode sweep, async reset.
module tb_shift_ex_stage;
  import wisc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_ex_stage_if bus ();

  shift_ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] rs,
                       input logic [3:0] imm, input logic [3:0] rd);
    bus.In_Valid  = v;
    bus.In_Opcode = op;
    bus.In_Rs     = rs;
    bus.In_Imm    = imm;
    bus.In_Rd     = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_shift(input int m, input logic [15:0] rs, input int amt);
    logic [15:0] r;
    r = rs;
    for (int k = 0; k < amt; k++) begin
      case (m)
        0:       r = {r[14:0], 1'b0};
        1:       r = {1'b0, r[15:1]};
        default: r = {r[0], r[15:1]};
      endcase
    end
    return r;
  endfunction

  initial begin
    logic [3:0]  ops [3];
    logic [15:0] rs, exp_r;
    ops[0] = 4'b0100; ops[1] = 4'b0101; ops[2] = 4'b0110;

    drive(1'b0, 4'b0000, 16'h0000, 4'h0, 4'h0);
    bus.Flush = 1'b0;
    bus.Out_Ready = 1'b1;

    // reset state
    #12;
    chk("rst_valid",   bus.Out_Valid, 1'b0);
    chk("rst_result",  bus.Out_Result, 16'h0000);
    chk("rst_rd",      bus.Out_Rd, 4'h0);
    chk("rst_wren",    bus.Out_WrEn, 1'b0);
    chk("rst_z",       bus.Z_Flag, 1'b0);
    chk("rst_illegal", bus.Illegal_Op, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // basic ops
    drive(1'b1, 4'b0100, 16'h8001, 4'd1, 4'd3);
    chk("sll_in_ready", bus.In_Ready, 1'b1);
    chk("sll_not_yet", bus.Out_Valid, 1'b0);
    tick();
    chk("sll_valid", bus.Out_Valid, 1'b1);
    chk("sll_result", bus.Out_Result, 16'h0002);
    chk("sll_rd", bus.Out_Rd, 4'd3);
    chk("sll_wren", bus.Out_WrEn, 1'b1);
    chk("sll_z", bus.Z_Flag, 1'b0);
    drive(1'b1, 4'b0101, 16'h8000, 4'd15, 4'd4);
    tick();
    chk("sra_result", bus.Out_Result, 16'h0001);
    chk("sra_z", bus.Z_Flag, 1'b0);
    drive(1'b1, 4'b0110, 16'h0001, 4'd4, 4'd5);
    tick();
    chk("ror_result", bus.Out_Result, 16'h1000);
    drive(1'b1, 4'b0100, 16'h8000, 4'd1, 4'd6);
    tick();
    chk("sll0_result", bus.Out_Result, 16'h0000);
    chk("sll0_z", bus.Z_Flag, 1'b1);
    drive(1'b0, 4'b0000, 16'h0000, 4'h0, 4'h0);
    tick();
    chk("drain_valid", bus.Out_Valid, 1'b0);
    chk("drain_wren", bus.Out_WrEn, 1'b0);
    chk("drain_hold_rd", bus.Out_Rd, 4'd6);

    // backpressure
    drive(1'b1, 4'b0100, 16'h0003, 4'd2, 4'd5);
    tick();
    chk("bp_a_result", bus.Out_Result, 16'h000C);
    bus.Out_Ready = 1'b0;
    drive(1'b1, 4'b0110, 16'h00F0, 4'd4, 4'd6);
    #1;
    chk("bp_in_ready_low", bus.In_Ready, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_stall_valid", bus.Out_Valid, 1'b1);
      chk("bp_stall_result", bus.Out_Result, 16'h000C);
      chk("bp_stall_rd", bus.Out_Rd, 4'd5);
      chk("bp_stall_ready", bus.In_Ready, 1'b0);
    end
    bus.Out_Ready = 1'b1;
    #1;
    chk("bp_in_ready_high", bus.In_Ready, 1'b1);
    tick();
    chk("bp_b_result", bus.Out_Result, 16'h000F);
    chk("bp_b_rd", bus.Out_Rd, 4'd6);
    drive(1'b1, 4'b0101, 16'hFF00, 4'd8, 4'd7);
    tick();
    chk("b2b_c_result", bus.Out_Result, 16'h00FF);
    chk("b2b_c_valid", bus.Out_Valid, 1'b1);
    drive(1'b1, 4'b0100, 16'h0001, 4'd0, 4'd8);
    tick();
    chk("b2b_d_result", bus.Out_Result, 16'h0001);
    chk("b2b_d_rd", bus.Out_Rd, 4'd8);
    chk("b2b_d_z", bus.Z_Flag, 1'b0);

    // flush while holding a stalled result
    bus.Out_Ready = 1'b0;
    bus.Flush = 1'b1;
    drive(1'b1, 4'b0100, 16'h8000, 4'd1, 4'd9);
    tick();
    chk("flush_valid", bus.Out_Valid, 1'b0);
    chk("flush_wren", bus.Out_WrEn, 1'b0);
    chk("flush_z", bus.Z_Flag, 1'b0);
    chk("flush_hold_result", bus.Out_Result, 16'h0001);
    bus.Flush = 1'b0;
    bus.Out_Ready = 1'b1;

    // illegal opcode; Z is first set so that "unchanged" is observable
    drive(1'b1, 4'b0100, 16'h8000, 4'd1, 4'd2);
    tick();
    chk("pre_ill_z", bus.Z_Flag, 1'b1);
    drive(1'b1, 4'b0000, 16'h1234, 4'd3, 4'd7);
    tick();
    chk("ill_valid", bus.Out_Valid, 1'b1);
    chk("ill_result", bus.Out_Result, 16'h1234);
    chk("ill_rd", bus.Out_Rd, 4'd7);
    chk("ill_wren", bus.Out_WrEn, 1'b0);
    chk("ill_flag", bus.Illegal_Op, 1'b1);
    chk("ill_z", bus.Z_Flag, 1'b1);
    drive(1'b1, 4'b0110, 16'h0001, 4'd1, 4'd1);
    tick();
    chk("post_ill_result", bus.Out_Result, 16'h8000);
    chk("post_ill_wren", bus.Out_WrEn, 1'b1);
    chk("post_ill_sticky", bus.Illegal_Op, 1'b1);
    chk("post_ill_z", bus.Z_Flag, 1'b0);

    // sweep of every shift amount in every mode
    for (int m = 0; m < 3; m++) begin
      for (int a = 0; a < 16; a++) begin
        rs = (a == 7) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
        exp_r = ref_shift(m, rs, a);
        drive(1'b1, ops[m], rs, 4'(a), 4'(a));
        tick();
        chk($sformatf("sweep_m%0d_a%0d_rs%04h", m, a, rs), bus.Out_Result, exp_r);
        chk($sformatf("sweep_z_m%0d_a%0d", m, a), bus.Z_Flag, (exp_r == 16'h0000));
      end
    end

    // asynchronous reset between edges
    drive(1'b1, 4'b0100, 16'h0001, 4'd1, 4'd3);
    tick();
    chk("mid_valid_before", bus.Out_Valid, 1'b1);
    drive(1'b0, 4'b0000, 16'h0000, 4'h0, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.Out_Valid, 1'b0);
    chk("mid_rst_wren", bus.Out_WrEn, 1'b0);
    chk("mid_rst_z", bus.Z_Flag, 1'b0);
    chk("mid_rst_illegal", bus.Illegal_Op, 1'b0);
    chk("mid_rst_result", bus.Out_Result, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
